// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one operand bit per clock, LSB first, over WIDTH cycles.
// Opcodes: AND, OR, XOR, NOT A, ADD, SUB; 110/111 yield zero.
module bit_serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_shadow;
  logic [2:0]       r_sel;
  logic             r_carry;

  logic             w_last, w_bsel, w_sum, w_cout, w_bit, w_cy;
  logic [WIDTH-1:0] w_res;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_res  = {w_bit, r_shadow[WIDTH-1:1]};
  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);

  // SUB is A + ~B with the carry preset to 1 at start.
  assign w_bsel = (r_sel == 3'b101) ? ~r_b[0] : r_b[0];
  assign w_sum  = r_a[0] ^ w_bsel ^ r_carry;
  assign w_cout = (r_a[0] & w_bsel) | (r_carry & (r_a[0] ^ w_bsel));

  always_comb begin
    w_bit = 1'b0;
    w_cy  = 1'b0;
    case (r_sel)
      3'b000:         w_bit = r_a[0] & r_b[0];
      3'b001:         w_bit = r_a[0] | r_b[0];
      3'b010:         w_bit = r_a[0] ^ r_b[0];
      3'b011:         w_bit = ~r_a[0];
      3'b100, 3'b101: begin
        w_bit = w_sum;
        w_cy  = w_cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_sel    <= '0;
      r_carry  <= 1'b0;
      result_o <= '0;
      carry_o  <= 1'b0;
      zero_o   <= 1'b1;
    end else if (r_state == IDLE && start_i) begin
      r_cnt    <= '0;
      r_a      <= a_i;
      r_b      <= b_i;
      r_sel    <= sel_i;
      r_carry  <= (sel_i == 3'b101);
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_shadow <= w_res;
      r_carry  <= w_cy;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        result_o <= w_res;
        carry_o  <= w_cy;
        zero_o   <= (w_res == '0);
      end
    end
  end
endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu: stimulus queues expected results,
// a negedge monitor checks each done_o pulse against the queue head.
module tb_bit_serial_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic [2:0]   sel_i = '0;
  logic         busy_o, done_o, carry_o, zero_o;
  logic [W-1:0] result_o;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    int           t;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, busy_cnt = 0, done_cnt = 0;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .sel_i(sel_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .carry_o(carry_o), .zero_o(zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: busy length, latency and result of every completion.
  always @(negedge clk) begin
    if (rst_i) busy_cnt = 0;
    else if (busy_o) busy_cnt++;
    if (done_o) begin
      exp_t e;
      done_cnt++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("result", {1'b0, result_o}, {1'b0, e.r});
        chk("carry", {{W{1'b0}}, carry_o}, {{W{1'b0}}, e.c});
        chk("zero", {{W{1'b0}}, zero_o}, {{W{1'b0}}, e.z});
        chk("latency", (W+1)'(cyc), (W+1)'(e.t));
        chk("busy_len", (W+1)'(busy_cnt), (W+1)'(W));
      end
      busy_cnt = 0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel,
                       input logic [W-1:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    a_i = a; b_i = b; sel_i = sel; start_i = 1'b1;
    @(posedge clk); #1;
    e.r = er; e.c = ec; e.z = (er == '0); e.t = cyc + W;
    q.push_back(e);
    @(negedge clk);
    start_i = 1'b0;
    a_i = ~a; b_i = ~b; sel_i = ~sel;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: got %0d pending ops expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_busy"}, {{W{1'b0}}, busy_o}, '0);
    chk({nm, "_done"}, {{W{1'b0}}, done_o}, '0);
    chk({nm, "_result"}, {1'b0, result_o}, '0);
    chk({nm, "_carry"}, {{W{1'b0}}, carry_o}, '0);
    chk({nm, "_zero"}, {{W{1'b0}}, zero_o}, {{W{1'b0}}, 1'b1});
  endtask

  initial begin
    int d0;
    #12;
    chk_reset_outs("por");
    @(negedge clk); rst_i = 1'b0;

    issue(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0);
    wait_idle();

    // Asynchronous reset between edges must clear outputs at once.
    #2 rst_i = 1'b1;
    #1 chk_reset_outs("async_rst");
    @(negedge clk); rst_i = 1'b0;

    issue(32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000000, 1'b1);
    wait_idle();
    issue(32'h00000005, 32'h00000007, 3'b101, 32'hFFFFFFFE, 1'b0);
    wait_idle();
    issue(32'h00000007, 32'h00000005, 3'b101, 32'h00000002, 1'b1);
    wait_idle();
    issue(32'h00000009, 32'h00000009, 3'b101, 32'h00000000, 1'b1);
    wait_idle();
    issue(32'h7FFFFFFF, 32'h00000001, 3'b100, 32'h80000000, 1'b0);
    wait_idle();
    issue(32'h00FF0000, 32'h0000000F, 3'b001, 32'h00FF000F, 1'b0);
    wait_idle();
    issue(32'h12345678, 32'hFFFF0000, 3'b010, 32'hEDCB5678, 1'b0);
    wait_idle();
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h00000000, 1'b0);
    wait_idle();

    // start_i and operand changes during RUN are ignored.
    d0 = done_cnt;
    issue(32'h00000000, 32'h00000000, 3'b011, 32'hFFFFFFFF, 1'b0);
    repeat (3) @(negedge clk);
    start_i = 1'b1; a_i = 32'hFFFFFFFF;
    @(negedge clk); start_i = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    chk("ignored_start_dones", (W+1)'(done_cnt - d0), (W+1)'(1));
    chk("ignored_start_busy", {{W{1'b0}}, busy_o}, '0);

    // Abort an ADD at bit-cycle 10.
    d0 = done_cnt;
    issue(32'h00000001, 32'h00000002, 3'b100, 32'h00000003, 1'b0);
    repeat (9) @(posedge clk);
    void'(q.pop_back());
    #2 rst_i = 1'b1;
    #1 chk_reset_outs("abort");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", (W+1)'(done_cnt - d0), '0);
    chk("abort_result_held", {1'b0, result_o}, '0);

    issue(32'h00000003, 32'h00000004, 3'b100, 32'h00000007, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 Port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start_i, input, 1 bit: request a new operation; honoured in IDLE only.
REQ-006 Port a_i, input, WIDTH bits: operand A; sampled only on the start edge.
REQ-007 Port b_i, input, WIDTH bits: operand B; sampled only on the start edge.
REQ-008 Port sel_i, input, 3 bits: opcode; sampled only on the start edge.
REQ-009 Port busy_o, output, 1 bit: high while in RUN.
REQ-010 Port done_o, output, 1 bit: single-cycle completion pulse.
REQ-011 Port result_o, output, WIDTH bits: registered result of the last completed operation.
REQ-012 Port carry_o, output, 1 bit: final carry of the last completed operation.
REQ-013 Port zero_o, output, 1 bit: high when result_o == 0.

Function
REQ-014 Opcodes SHALL be:
- 000 AND
- 001 OR
- 010 XOR
- 011 NOT A
- 100 ADD (A+B)
- 101 SUB (A-B, computed as A+~B+1)
- 110/111 reserved: result 0, carry 0.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 FSM transitions SHALL be:
- IDLE->RUN on start_i=1.
- RUN->DONE after WIDTH bit-cycles.
- DONE->IDLE unconditionally after one cycle.
REQ-017 On the start edge (E0), the block SHALL capture a_i, b_i and sel_i into internal shift registers, clear the bit counter, and preset the serial carry to 1 for SUB and 0 otherwise.
REQ-018 At each edge Ek (k=1..WIDTH) in RUN, the block SHALL process bit k-1, LSB first, using the 1-bit function selected by sel, and shift the result bit into an internal shadow register from the MSB end.
REQ-019 ADD and SUB SHALL propagate the serial carry from bit to bit; for logic and reserved opcodes the serial carry SHALL be held at 0.
REQ-020 At edge E(WIDTH), the block SHALL load result_o from the shadow register, load carry_o from the final carry, set zero_o to (result==0), and enter DONE.
REQ-021 done_o SHALL be high only while in DONE, i.e. for exactly one cycle, first visible WIDTH edges after the start edge.
REQ-022 busy_o SHALL be high from E0 through E(WIDTH-1) inclusive, i.e. exactly WIDTH cycles.
REQ-023 result_o, carry_o and zero_o SHALL hold their previous values throughout RUN and DONE and until the next completion.
REQ-024 start_i asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 Changes on a_i, b_i or sel_i after E0 SHALL have no effect on the current operation.
REQ-026 For SUB, carry_o=1 SHALL mean no borrow (A >= B unsigned).
REQ-027 ADD overflow SHALL wrap modulo 2^WIDTH, with carry_o=1.

Reset
REQ-028 rst_i=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE
- busy_o=0, done_o=0
- result_o=0, carry_o=0, zero_o=1
- bit counter, shift registers and serial carry cleared.
REQ-029 rst_i asserted mid-RUN SHALL abort the operation without updating result_o beyond its reset value.
REQ-030 After an abort, the first start_i following rst_i release SHALL run a full WIDTH-cycle operation.

Verification (WIDTH=32)
REQ-031 Reset check: assert rst_i asynchronously between clock edges -> outputs immediately become busy_o=0, done_o=0, result_o=0, carry_o=0, zero_o=1.
REQ-032 AND latency check: a=F0F0F0F0, b=FF00FF00, sel=000, 1-cycle start -> busy_o high for 32 cycles; done_o pulses once, 32 edges after the start edge; result_o=F000F000, carry_o=0, zero_o=0.
REQ-033 ADD wrap check: a=FFFFFFFF, b=00000001, sel=100 -> result_o=00000000, carry_o=1, zero_o=1.
REQ-034 SUB check, two runs:
- a=5, b=7, sel=101 -> result_o=FFFFFFFE, carry_o=0.
- then a=7, b=5 -> result_o=00000002, carry_o=1.
REQ-035 Ignored-input check: a=0, sel=011 (NOT A), then during RUN pulse start_i and change a_i to FFFFFFFF -> result_o=FFFFFFFF, exactly one done_o pulse, no second operation started.
REQ-036 Mid-RUN reset check: assert rst_i at bit-cycle 10 of an ADD -> reset values as in REQ-028, no done_o pulse; a following start with a=3, b=4, sel=100 -> result_o=00000007.
